// File: rtl/cookie_pkg.sv
// Shared types and default constants for the cookie tally block and its BCD adder.
package cookie_pkg;

    typedef enum logic [1:0] {PLAY, DRAIN, BONUS, CLEAR} tally_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int          N_COOKIES_DEF    = 64;
    localparam int          SCORE_DIGITS_DEF = 4;
    localparam logic [15:0] POINTS_BCD_DEF   = 16'h0010;
    localparam logic [15:0] BONUS_BCD_DEF    = 16'h0500;
    localparam bcd_digit_t  BCD_NINE         = 4'h9;

endpackage

// File: rtl/cookie_tally_if.sv
// Bus between the cookie array / level controller (master) and the score tally (slave).
interface cookie_tally_if
    import cookie_pkg::*;
#(
    parameter int N_COOKIES    = N_COOKIES_DEF,
    parameter int SCORE_DIGITS = SCORE_DIGITS_DEF
);
    logic [N_COOKIES-1:0]            Not_ate;
    logic                            Level_start;
    logic [4*SCORE_DIGITS-1:0]       Score_bcd;
    logic [$clog2(N_COOKIES+1)-1:0]  Remaining;
    logic                            Eat_pulse;
    logic                            Level_clear;
    logic [3:0]                      Level_num;

    modport master (
        output Not_ate, Level_start,
        input  Score_bcd, Remaining, Eat_pulse, Level_clear, Level_num
    );

    modport slave (
        input  Not_ate, Level_start,
        output Score_bcd, Remaining, Eat_pulse, Level_clear, Level_num
    );
endinterface

// File: rtl/bcd_sat_add.sv
// Combinational packed-BCD adder with digit-wise carry; clamps to all nines on overflow.
module bcd_sat_add
    import cookie_pkg::*;
#(
    parameter int DIGITS = SCORE_DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                sat
);
    bcd_digit_t [DIGITS-1:0] raw;
    logic                    carry;
    logic [4:0]              digit_sum;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        raw       = '0;
        carry     = 1'b0;
        digit_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
            if (digit_sum > 5'd9) begin
                raw[i] = 4'(digit_sum - 5'd10);
                carry  = 1'b1;
            end else begin
                raw[i] = digit_sum[3:0];
                carry  = 1'b0;
            end
        end
        sat = carry;
        sum = carry ? {DIGITS{BCD_NINE}} : raw;
    end
endmodule

// File: rtl/cookie_tally.sv
// Cookie eat detector, remaining counter, saturating BCD score and level-clear FSM.
// Define COOKIE_TALLY_BONUS_EN to add a one-cycle BONUS state that awards BONUS_BCD.
module cookie_tally
    import cookie_pkg::*;
#(
    parameter int                        N_COOKIES    = N_COOKIES_DEF,
    parameter int                        SCORE_DIGITS = SCORE_DIGITS_DEF,
    parameter logic [4*SCORE_DIGITS-1:0] POINTS_BCD   = (4*SCORE_DIGITS)'(POINTS_BCD_DEF),
    parameter logic [4*SCORE_DIGITS-1:0] BONUS_BCD    = (4*SCORE_DIGITS)'(BONUS_BCD_DEF)
) (
    input logic           Clk,
    input logic           Reset,
    cookie_tally_if.slave bus
);
    localparam int CW = $clog2(N_COOKIES + 1);
    localparam int SW = 4 * SCORE_DIGITS;
    localparam int PW = 16;

    tally_state_t         state, state_next;
    logic [N_COOKIES-1:0] nate_q;
    logic [CW-1:0]        remaining_q;
    logic [PW-1:0]        pending_q;
    logic [SW-1:0]        score_q;
    logic                 eat_pulse_q;
    logic                 level_clear_q;
    logic [3:0]           level_num_q;

    logic [N_COOKIES-1:0] eat_vec;
    logic [CW-1:0]        k;
    logic                 restart;
    logic                 bonus_en;
    logic                 drain_en;
    logic                 add_en;
    logic [SW-1:0]        addend;
    logic [SW-1:0]        score_sum;
    logic                 add_sat_unused;

    function automatic logic [CW-1:0] popcount(input logic [N_COOKIES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < N_COOKIES; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    // Only falling edges of Not_ate count; a cookie reappearing is ignored.
    assign eat_vec = nate_q & ~bus.Not_ate;
    assign k       = popcount(eat_vec);
    assign restart = (state == CLEAR) && bus.Level_start;

`ifdef COOKIE_TALLY_BONUS_EN
    assign bonus_en = (state == BONUS);
    assign addend   = bonus_en ? BONUS_BCD : POINTS_BCD;
`else
    logic unused_bonus;
    assign unused_bonus = ^BONUS_BCD;
    assign bonus_en     = 1'b0;
    assign addend       = POINTS_BCD;
`endif

    // The bonus cycle owns the adder; any pending points wait one cycle.
    assign drain_en = (pending_q != '0) && !bonus_en;
    assign add_en   = drain_en || bonus_en;

    bcd_sat_add #(.DIGITS(SCORE_DIGITS)) u_add (
        .a   (score_q),
        .b   (addend),
        .sum (score_sum),
        .sat (add_sat_unused)
    );

    always_comb begin
        state_next = state;
        case (state)
            PLAY:  if (remaining_q == '0) state_next = DRAIN;
`ifdef COOKIE_TALLY_BONUS_EN
            DRAIN: if (pending_q == '0) state_next = BONUS;
            BONUS: state_next = CLEAR;
`else
            DRAIN: if (pending_q == '0) state_next = CLEAR;
`endif
            CLEAR: if (bus.Level_start) state_next = PLAY;
            default: state_next = PLAY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= PLAY;
            // NOTE: nate_q resets to all ones so cookies already low are not scored as eaten.
            nate_q        <= '1;
            remaining_q   <= CW'(N_COOKIES);
            pending_q     <= '0;
            score_q       <= '0;
            eat_pulse_q   <= 1'b0;
            level_clear_q <= 1'b0;
            level_num_q   <= 4'd1;
        end else begin
            // NOTE: non-blocking assignments keep every register reading last cycle's values.
            state         <= state_next;
            nate_q        <= restart ? '1 : bus.Not_ate;
            eat_pulse_q   <= (k != '0);
            level_clear_q <= (state_next == CLEAR);
            pending_q     <= pending_q + PW'(k) - PW'(drain_en);
            if (add_en) score_q <= score_sum;
            if (restart)              remaining_q <= CW'(N_COOKIES);
            else if (k > remaining_q) remaining_q <= '0;
            else                      remaining_q <= remaining_q - k;
            if (restart && level_num_q != 4'd15) level_num_q <= level_num_q + 4'd1;
        end
    end

    assign bus.Score_bcd   = score_q;
    assign bus.Remaining   = remaining_q;
    assign bus.Eat_pulse   = eat_pulse_q;
    assign bus.Level_clear = level_clear_q;
    assign bus.Level_num   = level_num_q;
endmodule

// File: tb/tb_cookie_tally.sv
// Self-checking bench for cookie_tally: directed scenarios plus randomized eats against
// an integer-valued reference model (decimal score, cookie count, pending points).
module tb_cookie_tally;
    localparam int N = 64;

`ifdef COOKIE_TALLY_BONUS_EN
    localparam bit          BONUS_ON    = 1'b1;
    localparam logic [15:0] LEVEL_SCORE = 16'h1140;
`else
    localparam bit          BONUS_ON    = 1'b0;
    localparam logic [15:0] LEVEL_SCORE = 16'h0640;
`endif

    logic         Clk = 1'b0;
    logic         rst_in;
    logic [N-1:0] not_ate;
    logic         level_start;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_prev;
    int           m_remaining;
    int           m_pending;
    int           m_score;
    bit           m_pulse;
    int           m_level;
    int           m_phase;
    bit           m_clear;

    always #5 Clk = ~Clk;

    cookie_tally_if #(.N_COOKIES(N), .SCORE_DIGITS(4)) bus ();

    assign bus.Not_ate     = not_ate;
    assign bus.Level_start = level_start;

    cookie_tally #(.N_COOKIES(N), .SCORE_DIGITS(4)) dut (
        .Clk   (Clk),
        .Reset (rst_in),
        .bus   (bus)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        return r;
    endfunction

    function automatic int sat9999(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic model_step(input logic [N-1:0] ne, input logic ls, input logic rst);
        int k;
        bit restart;
        bit bonus;
        bit drain;
        int nphase;
        if (rst) begin
            m_prev = '1; m_remaining = N; m_pending = 0; m_score = 0;
            m_pulse = 0; m_level = 1; m_phase = 0; m_clear = 0;
        end else begin
            k       = $countones(m_prev & ~ne);
            restart = (m_phase == 3) && ls;
            bonus   = (m_phase == 2);
            drain   = (m_pending > 0) && !bonus;
            nphase  = m_phase;
            case (m_phase)
                0: if (m_remaining == 0) nphase = 1;
                1: if (m_pending == 0) nphase = BONUS_ON ? 2 : 3;
                2: nphase = 3;
                default: if (ls) nphase = 0;
            endcase
            if (bonus)      m_score = sat9999(m_score + 500);
            else if (drain) m_score = sat9999(m_score + 10);
            m_remaining = restart ? N : ((k > m_remaining) ? 0 : m_remaining - k);
            m_pending   = m_pending + k - (drain ? 1 : 0);
            m_pulse     = (k > 0);
            m_prev      = restart ? '1 : ne;
            if (restart && m_level < 15) m_level++;
            m_phase = nphase;
            m_clear = (nphase == 3);
        end
    endtask

    // Advance one clock; outputs are stable for sampling 1 ns after the edge.
    task automatic tick();
        logic [N-1:0] ne;
        logic         ls;
        logic         rst;
        ne  = not_ate;
        ls  = level_start;
        rst = rst_in;
        @(posedge Clk);
        #1;
        model_step(ne, ls, rst);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; not_ate = '1; level_start = 1'b0;
        tick(); tick();
        checks++; if (bus.Score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got=%h exp=0000", bus.Score_bcd); end
        checks++; if (bus.Remaining !== 7'd64) begin errors++; $display("FAIL reset_remaining got=%0d exp=64", bus.Remaining); end
        checks++; if (bus.Level_num !== 4'd1) begin errors++; $display("FAIL reset_level got=%0d exp=1", bus.Level_num); end
        checks++; if (bus.Level_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got=%b exp=0", bus.Level_clear); end
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.Eat_pulse !== 1'b0) begin errors++; $display("FAIL idle_pulse cycle %0d got=%b exp=0", i, bus.Eat_pulse); end
        end
        checks++; if (bus.Score_bcd !== 16'h0000) begin errors++; $display("FAIL idle_score got=%h exp=0000", bus.Score_bcd); end
        checks++; if (bus.Remaining !== 7'd64) begin errors++; $display("FAIL idle_remaining got=%0d exp=64", bus.Remaining); end
    endtask

    task automatic test_single_eat();
        not_ate[5] = 1'b0;
        tick();
        checks++; if (bus.Eat_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%b exp=1", bus.Eat_pulse); end
        checks++; if (bus.Remaining !== 7'd63) begin errors++; $display("FAIL single_remaining got=%0d exp=63", bus.Remaining); end
        checks++; if (bus.Score_bcd !== 16'h0000) begin errors++; $display("FAIL single_score_early got=%h exp=0000", bus.Score_bcd); end
        tick();
        checks++; if (bus.Eat_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_drop got=%b exp=0", bus.Eat_pulse); end
        checks++; if (bus.Score_bcd !== 16'h0010) begin errors++; $display("FAIL single_score got=%h exp=0010", bus.Score_bcd); end
        not_ate[5] = 1'b1;
        tick(); tick();
        checks++; if (bus.Remaining !== 7'd63 || bus.Eat_pulse !== 1'b0 || bus.Score_bcd !== 16'h0010) begin
            errors++; $display("FAIL raise_ignored got rem=%0d pulse=%b score=%h exp rem=63 pulse=0 score=0010",
                                bus.Remaining, bus.Eat_pulse, bus.Score_bcd);
        end
    endtask

    task automatic test_multi_eat();
        not_ate[3:1] = 3'b000;
        tick();
        checks++; if (bus.Eat_pulse !== 1'b1) begin errors++; $display("FAIL multi_pulse got=%b exp=1", bus.Eat_pulse); end
        checks++; if (bus.Remaining !== 7'd60) begin errors++; $display("FAIL multi_remaining got=%0d exp=60", bus.Remaining); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.Eat_pulse !== 1'b0) begin errors++; $display("FAIL multi_pulse_once cycle %0d got=%b exp=0", i, bus.Eat_pulse); end
            checks++; if (bus.Score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL multi_drain cycle %0d got=%h exp=%h", i, bus.Score_bcd, to_bcd(m_score)); end
        end
        checks++; if (bus.Score_bcd !== 16'h0040) begin errors++; $display("FAIL multi_score got=%h exp=0040", bus.Score_bcd); end
    endtask

    task automatic test_random();
        int b;
        for (int c = 0; c < 300; c++) begin
            b = $urandom_range(31, 8);
            if ($urandom_range(3, 0) == 0) not_ate[b] = ~not_ate[b];
            if ($urandom_range(7, 0) == 0) not_ate[$urandom_range(31, 8)] = 1'b0;
            level_start = ($urandom_range(9, 0) == 0);
            tick();
            checks++; if (bus.Score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL rand_score cycle %0d got=%h exp=%h", c, bus.Score_bcd, to_bcd(m_score)); end
            checks++; if (bus.Remaining !== 7'(m_remaining)) begin errors++; $display("FAIL rand_remaining cycle %0d got=%0d exp=%0d", c, bus.Remaining, m_remaining); end
            checks++; if (bus.Eat_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse cycle %0d got=%b exp=%b", c, bus.Eat_pulse, m_pulse); end
            checks++; if (bus.Level_clear !== m_clear || bus.Level_num !== 4'(m_level)) begin
                errors++; $display("FAIL rand_level cycle %0d got clear=%b num=%0d exp clear=%b num=%0d",
                                    c, bus.Level_clear, bus.Level_num, m_clear, m_level);
            end
        end
        level_start = 1'b0;
    endtask

    task automatic test_level_clear();
        int waited;
        rst_in = 1'b1; not_ate = '1; level_start = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        not_ate = '0;
        tick();
        checks++; if (bus.Eat_pulse !== 1'b1 || bus.Remaining !== 7'd0) begin
            errors++; $display("FAIL all_eaten got pulse=%b rem=%0d exp pulse=1 rem=0", bus.Eat_pulse, bus.Remaining);
        end
        waited = 0;
        while (bus.Level_clear !== 1'b1 && waited < 300) begin
            checks++; if (bus.Level_clear !== m_clear) begin errors++; $display("FAIL clear_timing cycle %0d got=%b exp=%b", waited, bus.Level_clear, m_clear); end
            tick();
            waited++;
        end
        checks++; if (bus.Level_clear !== 1'b1 || m_clear !== 1'b1) begin
            errors++; $display("FAIL clear_rise got=%b model=%b after %0d cycles", bus.Level_clear, m_clear, waited);
        end
        checks++; if (bus.Score_bcd !== LEVEL_SCORE) begin errors++; $display("FAIL level_score got=%h exp=%h", bus.Score_bcd, LEVEL_SCORE); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.Level_clear !== 1'b1) begin errors++; $display("FAIL clear_hold cycle %0d got=%b exp=1", i, bus.Level_clear); end
        end
        level_start = 1'b1; not_ate = '1;
        tick();
        level_start = 1'b0;
        checks++; if (bus.Level_clear !== 1'b0) begin errors++; $display("FAIL restart_clear got=%b exp=0", bus.Level_clear); end
        checks++; if (bus.Remaining !== 7'd64) begin errors++; $display("FAIL restart_remaining got=%0d exp=64", bus.Remaining); end
        checks++; if (bus.Level_num !== 4'd2) begin errors++; $display("FAIL restart_level got=%0d exp=2", bus.Level_num); end
        checks++; if (bus.Score_bcd !== LEVEL_SCORE) begin errors++; $display("FAIL restart_score_kept got=%h exp=%h", bus.Score_bcd, LEVEL_SCORE); end
        tick();
        checks++; if (bus.Eat_pulse !== 1'b0) begin errors++; $display("FAIL restart_no_eat got=%b exp=0", bus.Eat_pulse); end
    endtask

    task automatic test_saturation();
        int guard;
        guard = 0;
        while ((m_score + 10 * m_pending) < 9990 && guard < 5000) begin
            not_ate[40] = 1'b0; tick();
            not_ate[40] = 1'b1; tick();
            guard++;
        end
        guard = 0;
        while (m_pending > 0 && guard < 50) begin
            tick();
            guard++;
        end
        checks++; if (bus.Score_bcd !== to_bcd(m_score) || m_score != 9990) begin
            errors++; $display("FAIL preload_score got=%h exp=9990 model=%0d", bus.Score_bcd, m_score);
        end
        not_ate[42:41] = 2'b00;
        tick(); tick(); tick();
        checks++; if (bus.Score_bcd !== 16'h9999) begin errors++; $display("FAIL saturate got=%h exp=9999", bus.Score_bcd); end
        checks++; if (bus.Score_bcd !== to_bcd(m_score)) begin errors++; $display("FAIL saturate_model got=%h exp=%h", bus.Score_bcd, to_bcd(m_score)); end
    endtask

    task automatic test_reset_mid_drain();
        rst_in = 1'b1; not_ate = '1;
        tick();
        rst_in = 1'b0;
        tick();
        not_ate[3:1] = 3'b000;
        tick();
        checks++; if (bus.Eat_pulse !== 1'b1 || m_pending != 3) begin
            errors++; $display("FAIL pre_reset got pulse=%b exp=1 (model pending %0d)", bus.Eat_pulse, m_pending);
        end
        rst_in = 1'b1; not_ate = '1;
        tick();
        checks++; if (bus.Score_bcd !== 16'h0000 || bus.Remaining !== 7'd64 || bus.Eat_pulse !== 1'b0 ||
                      bus.Level_clear !== 1'b0 || bus.Level_num !== 4'd1) begin
            errors++; $display("FAIL mid_drain_reset got score=%h rem=%0d pulse=%b clear=%b num=%0d exp 0000/64/0/0/1",
                                bus.Score_bcd, bus.Remaining, bus.Eat_pulse, bus.Level_clear, bus.Level_num);
        end
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.Score_bcd !== 16'h0000) begin errors++; $display("FAIL post_reset_score cycle %0d got=%h exp=0000", i, bus.Score_bcd); end
        end
    endtask

    initial begin
        rst_in = 1'b1;
        not_ate = '1;
        level_start = 1'b0;
        test_reset();
        test_single_eat();
        test_multi_eat();
        test_random();
        test_level_clear();
        test_saturation();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cookie_tally.md
# cookie_tally

Downstream consumer of the per-cookie `Not_ate` flags. It detects each cookie's 1→0 transition, keeps a count of cookies still on the maze, and accumulates a saturating BCD score. A small FSM signals level completion to the game controller. It sits between the cookie array and the score/HUD text renderer and the level controller.

## Interface
Parameters:
- `N_COOKIES`, 64: number of cookie instances whose `Not_ate` bits are concatenated into the input vector.
- `SCORE_DIGITS`, 4: BCD digits of score.
- `POINTS_BCD`, 'h0010: BCD value added per eaten cookie.
- `BONUS_BCD`, 'h0500: BCD level-clear bonus, used only with `COOKIE_TALLY_BONUS_EN`.

Ports:
- `Clk`, input, 1: the single clock.
- `Reset`, input, 1: synchronous, active-high.
- `Not_ate`, input, N_COOKIES: bit i is 1 while cookie i is uneaten.
- `Level_start`, input, 1: one-cycle request from the level controller to begin the next level.
- `Score_bcd`, output, 4*SCORE_DIGITS: accumulated score, packed BCD, digit 0 in bits [3:0].
- `Remaining`, output, $clog2(N_COOKIES+1): cookies not yet eaten.
- `Eat_pulse`, output, 1: one-cycle strobe when at least one cookie is eaten (drives the chomp sound).
- `Level_clear`, output, 1: level-done level signal.
- `Level_num`, output, 4: current level, starting at 1.

## Operation
- Reset values: `Score_bcd` = 0, `Remaining` = N_COOKIES, `Eat_pulse` = 0, `Level_clear` = 0, `Level_num` = 1, state PLAY, `nate_q` = all ones, `pending` = 0.
- Edge detect: `nate_q <= Not_ate` every cycle. `eat_vec = nate_q & ~Not_ate`, and `k = popcount(eat_vec)`. Only 1→0 edges count; 0→1 edges (cookie reset) are ignored.
- When k > 0: `Remaining <= Remaining - k`, floored at 0. `Eat_pulse <= 1`. `pending` increases by k.
- Score drain: while `pending` != 0, each cycle `Score_bcd <= sat_add(Score_bcd, POINTS_BCD)` and `pending` decrements by 1. If an increment and a decrement happen in the same cycle, the net update is `pending + k - 1`.
- BCD arithmetic saturates: if the sum would exceed all nines, the score holds at all nines (9999 by default).
- FSM states:
  - PLAY: moves to DRAIN when `Remaining` reaches 0.
  - DRAIN: waits for `pending` == 0, then moves to CLEAR (or BONUS when configured).
  - CLEAR: asserts `Level_clear` (registered). On `Level_start` it moves to PLAY.
- `Level_start` in PLAY or DRAIN is ignored.
- On the CLEAR→PLAY transition:
  - `Remaining` reloads to N_COOKIES.
  - `nate_q` is forced to all ones.
  - `Level_num` increments, saturating at 15.
  - `Level_clear` drops.
  - Score is kept.
- `Reset` at any point, mid-drain included, restores all reset values on the next edge.

## Timing
- `Not_ate` bit first sampled 0 at edge t: `Remaining` and `Eat_pulse` update at edge t, visible in cycle t+1. `Eat_pulse` deasserts at t+1 unless a new eat occurs.
- The score for a single eat is visible after edge t+1 (latency 2 from input sample).
- k simultaneous eats finish scoring k cycles after detection.
- `Level_clear` asserts on the edge after the DRAIN exit condition (one extra cycle with BONUS) and holds until the cycle after `Level_start`.

## Configuration
- `COOKIE_TALLY_BONUS_EN` defined: DRAIN→BONUS→CLEAR. BONUS lasts exactly one cycle and adds `BONUS_BCD × 1` using the same saturating adder.
- Not defined: the BONUS state and `BONUS_BCD` usage are compiled out, and DRAIN goes directly to CLEAR.

## Structure
- Shared package `cookie_pkg`:
  - state enum `tally_state_t` (PLAY, DRAIN, BONUS, CLEAR).
  - BCD digit type.
  - default `POINTS_BCD`/`BONUS_BCD` constants.
  - `N_COOKIES` default.
- Sub-module `bcd_sat_add`: combinational packed-BCD adder, parameterised on digit count, with digit-wise carry and an all-nines saturation output.
- The popcount is a function local to `cookie_tally`.

## Test plan
- Reset, then hold `Not_ate` all ones for 10 cycles → Score 0, Remaining 64, `Eat_pulse` never high.
- Drop bit 5 at edge t → `Eat_pulse` high one cycle at t+1, Remaining 63, Score 0x0010 after t+1. Raising bit 5 again causes no change.
- Drop bits 1, 2, 3 in the same cycle → Remaining −3, one `Eat_pulse`, Score +0x0030 over three cycles.
- Preload score near 9990 via repeated eats, then eat 2 more → Score saturates at 0x9999.
- Eat all 64 cookies → `Level_clear` rises after the drain completes (score +0x0640; +0x0500 more with the bonus macro). `Level_start` → Remaining 64, `Level_num` 2, `Level_clear` 0.
- Assert `Reset` while `pending` = 3 → the next cycle shows all reset values and no further score change.
